tft_timing_gen: RTL
===================

// Module: tft_timing_gen
// PURPOSE
// Parametrised TFT/LCD raster timing generator for RGB-interface panels. It drives the panel
// clock, sync, DE and pixel bus, and runs a runtime-programmable display window with a
// pixel-request interface. Requests lead the pixel bus by a configurable latency, so a frame
// buffer or SDRAM reader can sit upstream. Sits between the pixel source and the panel pins.
// PARAMETERS
// H_SYNC   2    hsync width, clk cycles
// H_BACK   44   horizontal back porch
// H_DISP   800  active pixels per line
// H_FRONT  210  horizontal front porch; H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT
// V_SYNC   2    vsync width, lines
// V_BACK   22   vertical back porch
// V_DISP   480  active lines
// V_FRONT  22   vertical front porch; V_TOTAL = sum of the four V_* parameters
// CW       12   counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
// DW       24   pixel width
// REQ_LAT  2    cycles from tft_request to valid data_in, 1..8
// SYNC_POL 0    0: syncs low during sync period; 1: syncs high during sync period
// BG_COLOR 0    DW-bit colour driven inside the active area but outside the window
// PORTS
// clk          in  1    pixel clock
// rst          in  1    asynchronous, active-high reset
// en           in  1    timing enable
// win_x        in  CW   window x start, relative to the active area
// win_w        in  CW   window width
// win_y        in  CW   window y start
// win_h        in  CW   window height
// test_mode    in  1    colour-bar select; ignored unless TFT_TEST_PATTERN_EN is defined
// data_in      in  DW   pixel data, valid REQ_LAT cycles after tft_request
// tft_request  out 1    pixel request, one pixel per cycle
// hcount       out CW   window-relative x of the requested pixel; 0 when tft_request=0
// vcount       out CW   window-relative y of the requested pixel; 0 when tft_request=0
// frame_start  out 1    1-cycle pulse when hc=0 and vc=0
// tft_clk      out 1    equals clk
// tft_de       out 1    data enable
// tft_hsync    out 1    horizontal sync
// tft_vsync    out 1    vertical sync
// tft_rgb      out DW   pixel bus
// BEHAVIOUR
// - Internal counter hc runs 0..H_TOTAL-1. It wraps to 0, and vc (0..V_TOTAL-1) increments
//   when hc=H_TOTAL-1. vc wraps to 0 after V_TOTAL-1. No off-by-one extra count.
// - Active area: hc in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and vc in [V_SYNC+V_BACK,
//   V_SYNC+V_BACK+V_DISP). Active-relative coordinates: ax = hc-H_SYNC-H_BACK, ay likewise.
// - Window shadow: win_* are latched into shadow registers at reset release and in the cycle
//   with hc=H_TOTAL-1 and vc=V_TOTAL-1. Changes mid-frame have no effect until the next frame.
// - Clipping: window x end = min(win_x+win_w, H_DISP), computed CW+1 bits wide. win_w=0 or
//   win_x>=H_DISP gives no requests. The same rules apply to y.
// - tft_request, hcount, vcount and frame_start are registered and lag the counter by 1 cycle.
//   hcount = ax-win_x, vcount = ay-win_y.
// - tft_de, syncs and tft_rgb lag tft_request by REQ_LAT+1 cycles, via a delay line of
//   REQ_LAT stages plus an output register.
// - tft_rgb inside the window = data_in sampled exactly REQ_LAT cycles after the request.
//   Inside active area but outside window: BG_COLOR. Outside active area: 0.
// - tft_hsync is active while hc<H_SYNC and tft_vsync while vc<V_SYNC, polarity per SYNC_POL.
// - en=0: counters clear to 0 on the next clk and hold. Request/DE outputs go to 0, syncs go
//   inactive and tft_rgb goes to 0 (the delay line flushes to idle values). en 0->1 starts at
//   hc=vc=0, with frame_start one cycle later.
// - rst=1 (at any time, including mid-line): counters, shadows, delay line and all outputs
//   clear at once. tft_request, hcount, vcount, frame_start, tft_de and tft_rgb become 0.
//   Syncs become inactive (1 if SYNC_POL=0).
// CONFIGURATION
// - TFT_TEST_PATTERN_EN defined: with test_mode=1, every active pixel shows 8 vertical bars,
//   replacing data_in and BG_COLOR. Bar index = ax*8/H_DISP. Colours in order: white, yellow,
//   cyan, green, magenta, red, blue, black (8 bits per channel, scaled to DW). tft_request
//   keeps running. test_mode is sampled with the same delay as the pixel path.
// - TFT_TEST_PATTERN_EN undefined: test_mode is ignored and no bar logic is generated.
// TESTING
// Small bench parameters: H = 2/3/8/2 (H_TOTAL=15), V = 1/2/4/1 (V_TOTAL=8), REQ_LAT=2.
// - Free run, full window (0,0,8,4) -> frame_start every 120 clk. tft_de high 8 cycles per
//   line on 4 lines. tft_hsync low 2 of 15 cycles.
// - Window (2,1,3,2), data_in=counter -> 3x2 requests, hcount 0..2 and vcount 0..1. tft_rgb
//   shows data_in from 2 cycles after each request; other active pixels show BG_COLOR.
// - Window (6,3,5,5) -> clipped to 2x1 requests: hcount 0..1 on active line 3 only.
// - Write win_* mid-frame -> current frame unchanged; the new window applies from the next
//   frame_start.
// - en low for 20 cycles mid-line -> outputs idle within REQ_LAT+2 cycles. On restart,
//   frame_start comes one cycle after en rises.
// - rst pulse mid-active-line -> all outputs at reset values in the same cycle, then a clean
//   frame. With the macro defined and test_mode=1: 8 bars, one per active pixel.

Source files
------------

// File: rtl/tft_timing_gen.sv
// RGB-panel raster timing generator with a shadowed, clipped display window and a
// latency-matched pixel request interface. Define TFT_TEST_PATTERN_EN to build colour bars.
module tft_timing_gen #(
   parameter int unsigned    H_SYNC   = 2,
   parameter int unsigned    H_BACK   = 44,
   parameter int unsigned    H_DISP   = 800,
   parameter int unsigned    H_FRONT  = 210,
   parameter int unsigned    V_SYNC   = 2,
   parameter int unsigned    V_BACK   = 22,
   parameter int unsigned    V_DISP   = 480,
   parameter int unsigned    V_FRONT  = 22,
   parameter int unsigned    CW       = 12,
   parameter int unsigned    DW       = 24,
   parameter int unsigned    REQ_LAT  = 2,
   parameter int unsigned    SYNC_POL = 0,
   parameter logic [DW-1:0]  BG_COLOR = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [CW-1:0] win_x,
   input  logic [CW-1:0] win_w,
   input  logic [CW-1:0] win_y,
   input  logic [CW-1:0] win_h,
   input  logic          test_mode,
   input  logic [DW-1:0] data_in,
   output logic          tft_request,
   output logic [CW-1:0] hcount,
   output logic [CW-1:0] vcount,
   output logic          frame_start,
   output logic          tft_clk,
   output logic          tft_de,
   output logic          tft_hsync,
   output logic          tft_vsync,
   output logic [DW-1:0] tft_rgb
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
   localparam int unsigned H_ACT0  = H_SYNC + H_BACK;
   localparam int unsigned V_ACT0  = V_SYNC + V_BACK;
   localparam int unsigned LAST    = REQ_LAT - 1;
   localparam logic        SYNC_ACT = (SYNC_POL != 0);

   assign tft_clk = clk;

   // ---------------------------------------------------------------------------------------
   // Raster counters
   // ---------------------------------------------------------------------------------------
   logic [CW-1:0] hc, vc;
   logic          h_last, v_last, frame_end;

   assign h_last    = (hc == CW'(H_TOTAL - 1));
   assign v_last    = (vc == CW'(V_TOTAL - 1));
   assign frame_end = en && h_last && v_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hc <= '0;
         vc <= '0;
      end else if (!en) begin
         hc <= '0;
         vc <= '0;
      end else if (h_last) begin
         hc <= '0;
         vc <= v_last ? '0 : vc + CW'(1);
      end else begin
         hc <= hc + CW'(1);
      end
   end

   // ---------------------------------------------------------------------------------------
   // Window shadow registers: loaded once after reset, then only at the frame boundary
   // ---------------------------------------------------------------------------------------
   logic [CW-1:0] sx, sw, sy, sh;
   logic          loaded;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sx     <= '0;
         sw     <= '0;
         sy     <= '0;
         sh     <= '0;
         loaded <= 1'b0;
      end else if (!loaded || frame_end) begin
         sx     <= win_x;
         sw     <= win_w;
         sy     <= win_y;
         sh     <= win_h;
         loaded <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Position decode and window clipping
   // ---------------------------------------------------------------------------------------
   logic          h_act, v_act;
   logic [CW-1:0] ax, ay;
   logic [CW:0]   x_sum, y_sum, x_end, y_end;
   logic          in_x, in_y, in_win;

   always_comb begin
      h_act  = (hc >= CW'(H_ACT0)) && (hc < CW'(H_ACT0 + H_DISP));
      v_act  = (vc >= CW'(V_ACT0)) && (vc < CW'(V_ACT0 + V_DISP));
      ax     = hc - CW'(H_ACT0);
      ay     = vc - CW'(V_ACT0);
      // Extra bit keeps win_x + win_w from wrapping before the clip compare.
      x_sum  = {1'b0, sx} + {1'b0, sw};
      y_sum  = {1'b0, sy} + {1'b0, sh};
      x_end  = (x_sum > (CW+1)'(H_DISP)) ? (CW+1)'(H_DISP) : x_sum;
      y_end  = (y_sum > (CW+1)'(V_DISP)) ? (CW+1)'(V_DISP) : y_sum;
      in_x   = h_act && (ax >= sx) && ({1'b0, ax} < x_end);
      in_y   = v_act && (ay >= sy) && ({1'b0, ay} < y_end);
      in_win = en && in_x && in_y;
   end

`ifdef TFT_TEST_PATTERN_EN
   logic [CW+2:0] ax_x8;
   logic [2:0]    bar;

   always_comb begin
      ax_x8 = {3'b000, ax} << 3;
      bar   = 3'(ax_x8 / (CW+3)'(H_DISP));
   end

   // White, yellow, cyan, green, magenta, red, blue, black; each channel all-ones or zero.
   function automatic logic [DW-1:0] bar_color(input logic [2:0] idx);
      localparam int unsigned CH = DW / 3;
      logic [DW-1:0] c;
      c = '0;
      c[3*CH-1:2*CH] = {CH{~idx[1]}};
      c[2*CH-1:CH]   = {CH{~idx[2]}};
      c[CH-1:0]      = {CH{~idx[0]}};
      return c;
   endfunction
`else
   logic unused_test_mode;
   assign unused_test_mode = test_mode;
`endif

   // ---------------------------------------------------------------------------------------
   // Request stage: one cycle behind the counters
   // ---------------------------------------------------------------------------------------
   logic de1, hs1, vs1;
`ifdef TFT_TEST_PATTERN_EN
   logic       tm1;
   logic [2:0] bar1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tft_request <= 1'b0;
         hcount      <= '0;
         vcount      <= '0;
         frame_start <= 1'b0;
         de1         <= 1'b0;
         hs1         <= 1'b0;
         vs1         <= 1'b0;
`ifdef TFT_TEST_PATTERN_EN
         tm1         <= 1'b0;
         bar1        <= '0;
`endif
      end else begin
         tft_request <= in_win;
         hcount      <= in_win ? ax - sx : '0;
         vcount      <= in_win ? ay - sy : '0;
         frame_start <= en && (hc == '0) && (vc == '0);
         de1         <= en && h_act && v_act;
         hs1         <= en && (hc < CW'(H_SYNC));
         vs1         <= en && (vc < CW'(V_SYNC));
`ifdef TFT_TEST_PATTERN_EN
         tm1         <= test_mode;
         bar1        <= bar;
`endif
      end
   end

   // ---------------------------------------------------------------------------------------
   // Delay line matching the upstream read latency; flushes idle values when en drops
   // ---------------------------------------------------------------------------------------
   logic [REQ_LAT-1:0] de_pipe, win_pipe, hs_pipe, vs_pipe;
`ifdef TFT_TEST_PATTERN_EN
   logic [REQ_LAT-1:0] tm_pipe;
   logic [2:0]         bar_pipe [REQ_LAT];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         de_pipe  <= '0;
         win_pipe <= '0;
         hs_pipe  <= '0;
         vs_pipe  <= '0;
`ifdef TFT_TEST_PATTERN_EN
         tm_pipe  <= '0;
         for (int i = 0; i < int'(REQ_LAT); i++) bar_pipe[i] <= '0;
`endif
      end else begin
         de_pipe[0]  <= de1;
         win_pipe[0] <= tft_request;
         hs_pipe[0]  <= hs1;
         vs_pipe[0]  <= vs1;
`ifdef TFT_TEST_PATTERN_EN
         tm_pipe[0]  <= tm1;
         bar_pipe[0] <= bar1;
`endif
         for (int i = 1; i < int'(REQ_LAT); i++) begin
            de_pipe[i]  <= de_pipe[i-1];
            win_pipe[i] <= win_pipe[i-1];
            hs_pipe[i]  <= hs_pipe[i-1];
            vs_pipe[i]  <= vs_pipe[i-1];
`ifdef TFT_TEST_PATTERN_EN
            tm_pipe[i]  <= tm_pipe[i-1];
            bar_pipe[i] <= bar_pipe[i-1];
`endif
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // Panel output register
   // ---------------------------------------------------------------------------------------
   logic [DW-1:0] pix_next;

   always_comb begin
      pix_next = '0;
      if (de_pipe[LAST]) begin
         pix_next = win_pipe[LAST] ? data_in : BG_COLOR;
`ifdef TFT_TEST_PATTERN_EN
         if (tm_pipe[LAST]) pix_next = bar_color(bar_pipe[LAST]);
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tft_de    <= 1'b0;
         tft_hsync <= ~SYNC_ACT;
         tft_vsync <= ~SYNC_ACT;
         tft_rgb   <= '0;
      end else begin
         tft_de    <= de_pipe[LAST];
         tft_hsync <= hs_pipe[LAST] ? SYNC_ACT : ~SYNC_ACT;
         tft_vsync <= vs_pipe[LAST] ? SYNC_ACT : ~SYNC_ACT;
         tft_rgb   <= pix_next;
      end
   end

endmodule
